// File: rtl/mac_accum.sv
`default_nettype none
// ============================================================================
// mac_accum : per-frame signed accumulator behind the 18x18 multiplier, with
//             valid/last re-timed to match the multiplier latency.
// Revision  : 1.0
// ============================================================================
module mac_accum #(
  parameter int MULT_LAT = 3,
  parameter int P_W      = 36,
  parameter int ACC_W    = 48,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [P_W-1:0]   p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic v_a;
  logic l_a;

  generate
    if (MULT_LAT == 0) begin : g_lat0
      assign v_a = in_valid;
      assign l_a = in_valid & in_last;
    end else begin : g_pipe
      logic [MULT_LAT-1:0] v_q;
      logic [MULT_LAT-1:0] l_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_q <= '0;
          l_q <= '0;
        end else begin
          v_q[0] <= in_valid;
          l_q[0] <= in_valid & in_last;
          for (int i = 1; i < MULT_LAT; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
          end
        end
      end

      assign v_a = v_q[MULT_LAT-1];
      assign l_a = l_q[MULT_LAT-1];
    end
  endgenerate

  logic [ACC_W-1:0] pext;
  logic [ACC_W-1:0] sum_w;
  logic             add_ovf;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             sof_q, sof_d;

  assign pext    = ACC_W'($signed(p));
  assign sum_w   = acc_q + pext;
  assign add_ovf = (acc_q[ACC_W-1] == pext[ACC_W-1]) && (sum_w[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    sof_d = sof_q;
    if (v_a) begin
      if (sof_q) begin
        acc_d = pext;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_w;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add_ovf;
      end
      sof_d = l_a;
    end
  end

  logic             out_valid_q;
  logic [ACC_W-1:0] out_acc_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;
  logic             overrun_q;
  logic             capture;
  logic             load;

  // A full holding register may still load if it is being drained this cycle.
  assign capture = v_a & l_a;
  assign load    = capture & (~out_valid_q | out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sof_q       <= 1'b1;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      sof_q <= sof_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_acc_q   <= acc_d;
        out_cnt_q   <= cnt_d;
        out_ovf_q   <= ovf_d;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (capture && !load) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;
  assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_accum.sv
`default_nettype none
// ============================================================================
// tb_mac_accum : randomized and directed checks of mac_accum against a
//                frame-level reference model.
// Revision     : 1.0
// ============================================================================
module tb_mac_accum;

  localparam int    LAT   = 3;
  localparam int    PW    = 36;
  localparam int    AW    = 48;
  localparam int    CW    = 16;
  localparam int    NC    = 4096;
  localparam longint AMASK = (64'sd1 <<< AW) - 1;
  localparam longint MAXV  = (64'sd1 <<< (AW - 1)) - 1;
  localparam longint MINV  = -(64'sd1 <<< (AW - 1));
  localparam int    CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_last, out_ready;
  logic [PW-1:0] p;
  logic          out_valid, out_ovf, overrun;
  logic [AW-1:0] out_acc;
  logic [CW-1:0] out_cnt;

  mac_accum #(.MULT_LAT(LAT), .P_W(PW), .ACC_W(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .p(p),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_cnt(out_cnt), .out_ovf(out_ovf), .overrun(overrun)
  );

  // Narrow-accumulator instance with no multiplier latency, for wrap/overflow.
  logic        o_rst_n, o_valid, o_last, o_ready;
  logic [35:0] o_p;
  logic        o_out_valid, o_out_ovf, o_overrun;
  logic [35:0] o_out_acc;
  logic [15:0] o_out_cnt;
  logic        ovf_done = 1'b0;

  mac_accum #(.MULT_LAT(0), .P_W(36), .ACC_W(36), .CNT_W(16)) u_ovf (
    .clk(clk), .rst_n(o_rst_n), .in_valid(o_valid), .in_last(o_last), .p(o_p),
    .out_valid(o_out_valid), .out_ready(o_ready), .out_acc(o_out_acc),
    .out_cnt(o_out_cnt), .out_ovf(o_out_ovf), .overrun(o_overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Operand-side history; the product for a beat issued at cycle c is driven at c+LAT.
  logic          hv [NC];
  logic          hl [NC];
  logic [PW-1:0] hp [NC];
  int            cyc = 0;
  int            last_rst = -1;

  // Reference model: current frame and the one-deep result holder.
  logic   m_sof = 1'b1;
  longint m_acc = 0;
  int     m_cnt = 0;
  logic   m_ovf = 1'b0;
  logic   m_hv = 1'b0;
  longint m_hacc = 0;
  int     m_hcnt = 0;
  logic   m_hovf = 1'b0;
  logic   m_ovr = 1'b0;

  function automatic logic [PW-1:0] pv(input longint x);
    logic [63:0] t;
    t = x;
    return t[PW-1:0];
  endfunction

  function automatic longint wrap(input longint t);
    longint m;
    m = t & AMASK;
    if (m[AW-1]) m = m - (64'sd1 <<< AW);
    return m;
  endfunction

  task automatic model_edge();
    logic   va, la, accept;
    longint pe, t;
    int     src;
    if (!rst_n) begin
      m_sof = 1'b1; m_acc = 0; m_cnt = 0; m_ovf = 1'b0;
      m_hv = 1'b0; m_hacc = 0; m_hcnt = 0; m_hovf = 1'b0; m_ovr = 1'b0;
      last_rst = cyc;
      return;
    end
    src    = cyc - LAT;
    va     = (src >= 0) && (src > last_rst) && hv[src];
    la     = va && hl[src];
    accept = m_hv && out_ready;
    if (va) begin
      pe = longint'($signed(hp[src]));
      if (m_sof) begin
        m_acc = pe; m_cnt = 1; m_ovf = 1'b0;
      end else begin
        t = m_acc + pe;
        m_ovf = m_ovf | (t > MAXV) | (t < MINV);
        m_acc = wrap(t);
        m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      end
      m_sof = la;
    end
    if (la && (!m_hv || out_ready)) begin
      m_hv = 1'b1; m_hacc = m_acc; m_hcnt = m_cnt; m_hovf = m_ovf;
    end else if (la) begin
      m_ovr = 1'b1;
    end else if (accept) begin
      m_hv = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic l, input logic [PW-1:0] prod,
                      input logic rdy, input logic rn);
    logic [63:0] junk;
    if (cyc >= NC) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, NC);
      $fatal(1, "cycle budget exceeded");
    end
    hv[cyc] = v; hl[cyc] = v & l; hp[cyc] = prod;
    in_valid = v; in_last = l; out_ready = rdy; rst_n = rn;
    junk = {$urandom, $urandom};
    p = (cyc >= LAT && hv[cyc-LAT]) ? hp[cyc-LAT] : junk[PW-1:0];
    @(posedge clk);
    model_edge();
    #1;
    check("m_valid", 64'(out_valid), 64'(m_hv));
    check("m_overrun", 64'(overrun), 64'(m_ovr));
    if (m_hv) begin
      check("m_acc", 64'(out_acc), 64'(m_hacc) & AMASK);
      check("m_cnt", 64'(out_cnt), 64'(m_hcnt));
      check("m_ovf", 64'(out_ovf), 64'(m_hovf));
    end
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, rdy, 1'b1);
  endtask

  function automatic logic [PW-1:0] rnd_p();
    logic [63:0] r;
    r = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) return r[PW-1:0];
    return pv(longint'($urandom_range(0, 2000)) - 1000);
  endfunction

  initial begin
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_acc", 64'(out_acc), 64'd0);
    check("rst_cnt", 64'(out_cnt), 64'd0);
    check("rst_ovf", 64'(out_ovf), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);

    // Basic four-beat frame
    step(1, 0, pv(10), 1, 1);
    step(1, 0, pv(-3), 1, 1);
    step(1, 0, pv(7), 1, 1);
    step(1, 1, pv(100), 1, 1);
    idle(2, 1);
    check("basic_early", 64'(out_valid), 64'd0);
    idle(1, 1);
    check("basic_valid", 64'(out_valid), 64'd1);
    check("basic_acc", 64'(out_acc), 64'd114);
    check("basic_cnt", 64'(out_cnt), 64'd4);
    check("basic_ovf", 64'(out_ovf), 64'd0);
    idle(1, 1);
    check("basic_fall", 64'(out_valid), 64'd0);

    // Back-to-back single-beat frames
    step(1, 1, pv(5), 1, 1);
    step(1, 1, pv(6), 1, 1);
    step(1, 1, pv(7), 1, 1);
    idle(1, 1);
    check("single_acc0", 64'(out_acc), 64'd5);
    check("single_cnt0", 64'(out_cnt), 64'd1);
    idle(1, 1);
    check("single_acc1", 64'(out_acc), 64'd6);
    check("single_v1", 64'(out_valid), 64'd1);
    idle(1, 1);
    check("single_acc2", 64'(out_acc), 64'd7);
    check("single_v2", 64'(out_valid), 64'd1);
    idle(1, 1);
    check("single_fall", 64'(out_valid), 64'd0);

    // Backpressure and overrun
    step(1, 0, pv(40), 0, 1);
    step(1, 1, pv(2), 0, 1);
    step(1, 1, pv(9), 0, 1);
    idle(4, 0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_acc", 64'(out_acc), 64'd42);
    check("bp_overrun", 64'(overrun), 64'd1);
    idle(1, 1);
    check("bp_fall", 64'(out_valid), 64'd0);
    check("bp_sticky", 64'(overrun), 64'd1);

    // Gaps inside a frame
    step(1, 0, pv(1), 1, 1);
    idle(2, 1);
    step(1, 0, pv(2), 1, 1);
    idle(1, 1);
    step(1, 1, pv(3), 1, 1);
    idle(3, 1);
    check("gap_acc", 64'(out_acc), 64'd6);
    check("gap_cnt", 64'(out_cnt), 64'd3);

    // Reset with products in flight
    step(1, 0, pv(50), 1, 1);
    step(1, 0, pv(60), 1, 1);
    step(0, 0, '0, 1, 0);
    step(1, 1, pv(8), 1, 1);
    idle(3, 1);
    check("rmid_valid", 64'(out_valid), 64'd1);
    check("rmid_acc", 64'(out_acc), 64'd8);
    check("rmid_cnt", 64'(out_cnt), 64'd1);
    check("rmid_overrun", 64'(overrun), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, rnd_p(),
           $urandom_range(0, 9) < 6, $urandom_range(0, 299) != 0);
    end
    idle(LAT + 2, 1);

    check("ovf_done", 64'(ovf_done), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    o_rst_n = 1'b0; o_valid = 1'b0; o_last = 1'b0; o_ready = 1'b1; o_p = '0;
    repeat (2) @(posedge clk);
    #1;
    o_rst_n = 1'b1;
    o_valid = 1'b1;
    o_p = 36'h4_0000_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ovf_mid_valid", 64'(o_out_valid), 64'd0);
    o_last = 1'b1;
    @(posedge clk); #1;
    check("ovf_valid", 64'(o_out_valid), 64'd1);
    check("ovf_acc", 64'(o_out_acc), 64'h0000_000C_0000_0000);
    check("ovf_flag", 64'(o_out_ovf), 64'd1);
    check("ovf_cnt", 64'(o_out_cnt), 64'd3);
    o_p = 36'd5;
    @(posedge clk); #1;
    check("clean_acc", 64'(o_out_acc), 64'd5);
    check("clean_ovf", 64'(o_out_ovf), 64'd0);
    check("clean_cnt", 64'(o_out_cnt), 64'd1);
    o_valid = 1'b0; o_last = 1'b0;
    @(posedge clk); #1;
    check("clean_fall", 64'(o_out_valid), 64'd0);
    check("ovf_no_overrun", 64'(o_overrun), 64'd0);
    ovf_done = 1'b1;
  end

endmodule
`default_nettype wire
